booth_sequencer: RTL and testbench

Control unit for the radix-2 Booth multiplier datapath. On a start request it loads the operand registers, then runs WORD_LENGTH evaluate/shift iterations. Each add/subtract decision is driven by the multiplier's two low-order bits, which the datapath feeds back. When the last shift is issued it signals completion. It sits between the top-level start/done interface and the datapath registers (accumulator, multiplier Q, Q[-1]) and owns the iteration counter.

---
 rtl/booth_sequencer.sv | 101 ++++++++++
 tb/tb_booth_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_sequencer.sv
// booth_sequencer: control FSM for a radix-2 Booth multiplier datapath.
// It sequences operand load, WORD_LENGTH evaluate/shift iterations and a
// one-cycle completion pulse, and owns the iteration counter.
module booth_sequencer #(
  parameter int WORD_LENGTH       = 16,
  parameter int NBITS_FOR_COUNTER = $clog2(WORD_LENGTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         q_lsb,
  input  logic                         q_prev,
  output logic                         load_operands,
  output logic                         add_en,
  output logic                         sub_en,
  output logic                         shift_en,
  output logic                         busy,
  output logic                         done,
  output logic [NBITS_FOR_COUNTER-1:0] iteration
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [NBITS_FOR_COUNTER-1:0] LAST_ITER = NBITS_FOR_COUNTER'(WORD_LENGTH - 1);
  localparam logic [NBITS_FOR_COUNTER-1:0] ONE       = NBITS_FOR_COUNTER'(1);

  state_t                         state;
  state_t                         state_nxt;
  logic [NBITS_FOR_COUNTER-1:0]   iter_cnt;
  logic [NBITS_FOR_COUNTER-1:0]   iter_cnt_nxt;

  // State and iteration counter registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_cnt_nxt;
    end
  end

  // Next-state, counter update and control strobes (add/sub decode is
  // combinational on the Booth pair so the datapath acts in the same cycle).
  always_comb begin
    state_nxt     = state;
    iter_cnt_nxt  = iter_cnt;
    load_operands = 1'b0;
    add_en        = 1'b0;
    sub_en        = 1'b0;
    shift_en      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        busy         = 1'b0;
        iter_cnt_nxt = '0;
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_operands = 1'b1;
        state_nxt     = EVAL;
      end
      EVAL: begin
        add_en    = ~q_lsb &  q_prev;
        sub_en    =  q_lsb & ~q_prev;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (iter_cnt == LAST_ITER) begin
          iter_cnt_nxt = '0;
          state_nxt    = DONE;
        end else begin
          iter_cnt_nxt = iter_cnt + ONE;
          state_nxt    = EVAL;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy         = 1'b0;
        iter_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase
  end

  assign iteration = iter_cnt;

endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: self-checking bench with two sequencer instances
// (WORD_LENGTH 4 and 16). A phase-count reference model predicts every
// output each cycle; the 16-bit instance drives a Booth datapath model
// whose product is compared against plain signed multiplication.
module tb_booth_sequencer;

  localparam int W4  = 4;
  localparam int W16 = 16;
  localparam int N4  = $clog2(W4 + 1);
  localparam int N16 = $clog2(W16 + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start4 = 1'b0, start16 = 1'b0;
  logic q4_lsb = 1'b0, q4_prev = 1'b0;
  logic load4, add4, sub4, shift4, busy4, done4;
  logic load16, add16, sub16, shift16, busy16, done16;
  logic [N4-1:0]  iter4;
  logic [N16-1:0] iter16;

  // Datapath model for the 16-bit instance
  logic signed [15:0] mcand = '0, mplier = '0;
  logic signed [15:0] acc = '0, mq = '0, mcd = '0;
  logic               qm1 = 1'b0;
  logic signed [31:0] exp_prod = '0;
  logic c_load = 1'b0, c_add = 1'b0, c_sub = 1'b0, c_shift = 1'b0;
  logic signed [15:0] c_mcand = '0, c_mplier = '0;

  int n_chk = 0;
  int n_fail = 0;
  int k4 = 0, k16 = 0;
  logic known = 1'b0;

  always #5 clk = ~clk;

  booth_sequencer #(.WORD_LENGTH(W4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .q_lsb(q4_lsb), .q_prev(q4_prev),
    .load_operands(load4), .add_en(add4), .sub_en(sub4), .shift_en(shift4),
    .busy(busy4), .done(done4), .iteration(iter4));

  booth_sequencer #(.WORD_LENGTH(W16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .q_lsb(mq[0]), .q_prev(qm1),
    .load_operands(load16), .add_en(add16), .sub_en(sub16), .shift_en(shift16),
    .busy(busy16), .done(done16), .iteration(iter16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the number of cycles k since start was accepted:
  // 1 = load, 2..2W+1 alternate evaluate/shift, 2W+2 = done, 0 = idle.
  function automatic logic [13:0] exp_outs(input int w, input int k, input logic ql, input logic qp);
    logic ld, ev, sh, ad, sb, bz, dn;
    int   it;
    ld = (k == 1);
    ev = (k >= 2) && (k <= 2*w+1) && (k % 2 == 0);
    sh = (k >= 2) && (k <= 2*w+1) && (k % 2 == 1);
    ad = ev && ({ql, qp} == 2'b01);
    sb = ev && ({ql, qp} == 2'b10);
    bz = (k != 0);
    dn = (k == 2*w+2);
    it = (ev || sh) ? (k - 2) / 2 : 0;
    return {ld, ad, sb, sh, bz, dn, 8'(it)};
  endfunction

  function automatic int next_k(input int w, input int k, input logic rst, input logic st);
    if (rst) return 0;
    if (k == 0) return st ? 1 : 0;
    if (k == 2*w+2) return 0;
    return k + 1;
  endfunction

  // Datapath registers update on the edge using controls sampled mid-cycle.
  always @(posedge clk) begin
    if (c_load) begin
      acc      <= '0;
      mq       <= c_mplier;
      qm1      <= 1'b0;
      mcd      <= c_mcand;
      exp_prod <= 32'(c_mcand) * 32'(c_mplier);
    end else if (c_add) begin
      acc <= acc + mcd;
    end else if (c_sub) begin
      acc <= acc - mcd;
    end else if (c_shift) begin
      {acc, mq, qm1} <= $signed({acc, mq, qm1}) >>> 1;
    end
  end

  // Compare process: check both instances every cycle, then advance models.
  always @(negedge clk) begin
    if (known) begin
      chk("outs4", {load4, add4, sub4, shift4, busy4, done4, 8'(iter4)},
          exp_outs(W4, k4, q4_lsb, q4_prev));
      chk("outs16", {load16, add16, sub16, shift16, busy16, done16, 8'(iter16)},
          exp_outs(W16, k16, mq[0], qm1));
      if (k16 == 2*W16+2) chk("prod16", {acc, mq}, exp_prod);
    end
    k4       <= next_k(W4, k4, reset, start4);
    k16      <= next_k(W16, k16, reset, start16);
    if (reset) known <= 1'b1;
    c_load   <= load16;
    c_add    <= add16;
    c_sub    <= sub16;
    c_shift  <= shift16;
    c_mcand  <= mcand;
    c_mplier <= mplier;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic mul16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] lit);
    int n;
    mcand = a; mplier = b; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    n = 1;
    while (!done16 && n < 60) begin cyc(); n++; end
    chk("lat16", n, 34);
    chk("prod_lit", {acc, mq}, lit);
    cyc();
  endtask

  logic [1:0] tbl [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  int it_exp [11] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    int nd, m;
    // Reset then idle
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (10) begin
      cyc();
      chk("idle", {busy4, done4, load4, shift4, busy16, done16, 8'(iter4), 8'(iter16)}, 32'd0);
    end

    // Single W=4 operation with q held 00
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      #1;
      chk("load4_lit", load4, 32'(n == 1));
      chk("shift4_lit", shift4, 32'(n == 3 || n == 5 || n == 7 || n == 9));
      chk("addsub4_lit", {add4, sub4}, 32'd0);
      chk("done4_lit", done4, 32'(n == 10));
      chk("iter4_lit", iter4, it_exp[n]);
      cyc();
    end

    // Decode coverage across successive EVAL cycles
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n % 2 == 0 && n <= 8) {q4_lsb, q4_prev} = tbl[(n-2)/2];
      else {q4_lsb, q4_prev} = 2'($urandom);
      #1;
      if (n % 2 == 0 && n <= 8) begin
        chk("dec_add", add4, 32'(n == 2));
        chk("dec_sub", sub4, 32'(n == 4));
      end
      cyc();
    end
    {q4_lsb, q4_prev} = 2'b00;

    // Start while busy: LOAD, EVAL and DONE ignored; held into IDLE restarts
    start4 = 1'b1;
    cyc();
    nd = 0;
    for (int n = 1; n <= 12; n++) begin
      start4 = (n <= 2) || (n == 10) || (n == 11);
      #1;
      if (done4) nd++;
      if (n == 11) chk("busy_idle", busy4, 32'd0);
      if (n == 12) chk("restart_load", load4, 32'd1);
      cyc();
    end
    chk("one_done", nd, 1);
    m = 2;
    while (!done4 && m < 30) begin cyc(); m++; end
    chk("lat4b", m, 10);
    cyc();

    // Directed multiplies on the 16-bit instance
    mul16(16'hFFF9, 16'h0003, 32'hFFFFFFEB);
    mul16(16'h7FFF, 16'h8000, 32'hC0008000);

    // Reset mid-operation at iteration 5 in SHIFT
    mcand = 16'sd123; mplier = -16'sd45; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    repeat (12) cyc();
    chk("mid_shift", {shift16, 8'(iter16)}, {1'b1, 8'd5});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort", {load16, add16, sub16, shift16, busy16, done16, 8'(iter16)}, 32'd0);
    mul16(16'h1234, 16'hFEDC, 32'(32'sh1234 * -32'sh124));

    // Randomised traffic on both instances, including occasional resets
    for (int n = 0; n < 1500; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      start4  = ($urandom_range(0, 2) == 0);
      start16 = ($urandom_range(0, 4) == 0);
      {q4_lsb, q4_prev} = 2'($urandom);
      mcand  = 16'($urandom);
      mplier = 16'($urandom);
      cyc();
    end
    reset = 1'b0; start4 = 1'b0; start16 = 1'b0;
    repeat (40) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
